// File: rtl/regp_stream_rd.sv
// Read-side sequencer: walks NUM_COEF register-file words from BASE_ADDR and streams them over valid/ready.
// Optional running-sum output enabled by defining REGP_STREAM_SUM_EN.
module regp_stream_rd #(
    parameter int unsigned DATA_W    = 45,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_COEF  = 23,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] regmel_addr,
    output logic              regmel_wren,
    input  logic [DATA_W-1:0] regmel_out,
    output logic [DATA_W-1:0] coef_data,
    output logic [ADDR_W-1:0] coef_idx,
    output logic              coef_last,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              busy,
    output logic              done
`ifdef REGP_STREAM_SUM_EN
    ,
    output logic [DATA_W+ADDR_W-1:0] coef_sum
`endif
);

    localparam int unsigned SUM_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COEF - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic              ONE_COEF = (NUM_COEF == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SUM_W-1:0]  sum_q, sum_d;

    logic accept_c;
    logic final_c;

    assign accept_c = (state_q == S_STREAM) && coef_ready;
    assign final_c  = accept_c && (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (final_c) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                addr_d = BASE;
                if (start) begin
                    busy_d = 1'b1;
                    sum_d  = '0;
                end
            end
            S_LOAD: begin
                data_d  = regmel_out;
                idx_d   = '0;
                valid_d = 1'b1;
                last_d  = ONE_COEF;
                addr_d  = addr_q + IDX_ONE;
            end
            S_STREAM: begin
                if (accept_c) begin
                    sum_d = sum_q + SUM_W'(data_q);
                    if (final_c) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        addr_d  = BASE;
                    end else begin
                        data_d = regmel_out;
                        idx_d  = idx_q + IDX_ONE;
                        last_d = ((idx_q + IDX_ONE) == LAST_IDX);
                        addr_d = addr_q + IDX_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= BASE;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
        end
    end

    assign regmel_addr = addr_q;
    assign regmel_wren = 1'b0;
    assign coef_data   = data_q;
    assign coef_idx    = idx_q;
    assign coef_last   = last_q;
    assign coef_valid  = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef REGP_STREAM_SUM_EN
    assign coef_sum = sum_q;
`else
    logic unused_sum_c;
    assign unused_sum_c = ^sum_q;
`endif

endmodule

// File: tb/tb_regp_stream_rd.sv
// Bench for regp_stream_rd: three instances (base/length corners) checked every cycle against a beat-level model.
module tb_regp_stream_rd;

    localparam int unsigned DW = 45;
    localparam int unsigned AW = 5;
    localparam int unsigned SW = DW + AW;
    localparam int unsigned NI = 3;

    logic clk;
    logic reset;
    logic start;
    logic ready;

    logic [DW-1:0] mem    [NI][32];
    logic [DW-1:0] rd     [NI];
    logic [AW-1:0] addr_o [NI];
    logic          wren_o [NI];
    logic [DW-1:0] data_o [NI];
    logic [AW-1:0] idx_o  [NI];
    logic          last_o [NI];
    logic          valid_o[NI];
    logic          busy_o [NI];
    logic          done_o [NI];
`ifdef REGP_STREAM_SUM_EN
    logic [SW-1:0] sum_o  [NI];
`endif

    function automatic int unsigned num_of(input int i);
        return (i == 2) ? 1 : 23;
    endfunction

    function automatic int unsigned base_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 9 : 31);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        regp_stream_rd #(
            .DATA_W   (DW),
            .ADDR_W   (AW),
            .NUM_COEF ((g == 2) ? 1 : 23),
            .BASE_ADDR((g == 0) ? 0 : ((g == 1) ? 9 : 31))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .regmel_addr(addr_o[g]),
            .regmel_wren(wren_o[g]),
            .regmel_out (rd[g]),
            .coef_data  (data_o[g]),
            .coef_idx   (idx_o[g]),
            .coef_last  (last_o[g]),
            .coef_valid (valid_o[g]),
            .coef_ready (ready),
            .busy       (busy_o[g]),
            .done       (done_o[g])
`ifdef REGP_STREAM_SUM_EN
            ,
            .coef_sum   (sum_o[g])
`endif
        );
        assign rd[g] = mem[g][addr_o[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Beat-level reference: frame in flight, load phase, beats accepted, captured word, running sum
    bit            m_active[NI];
    bit            m_load  [NI];
    bit            m_valid [NI];
    bit            m_done  [NI];
    bit            m_fresh [NI];
    int            m_beats [NI];
    logic [DW-1:0] m_data  [NI];
    logic [SW-1:0] m_sum   [NI];

    int xfer0;
    int done_cnt0;

    task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int n;
            int b;
            n = int'(num_of(i));
            b = int'(base_of(i));
            if (reset) begin
                m_active[i] = 0; m_load[i] = 0; m_valid[i] = 0; m_done[i] = 0;
                m_beats[i] = 0; m_data[i] = '0; m_sum[i] = '0; m_fresh[i] = 1;
            end else if (m_done[i]) begin
                m_done[i] = 0;
            end else if (!m_active[i]) begin
                if (start) begin
                    m_active[i] = 1; m_load[i] = 1; m_sum[i] = '0; m_fresh[i] = 0;
                end
            end else if (m_load[i]) begin
                m_load[i]  = 0;
                m_valid[i] = 1;
                m_beats[i] = 0;
                m_data[i]  = mem[i][b];
            end else if (ready) begin
                m_sum[i] = m_sum[i] + SW'(m_data[i]);
                if (m_beats[i] == n - 1) begin
                    m_active[i] = 0; m_valid[i] = 0; m_done[i] = 1;
                end else begin
                    m_beats[i] = m_beats[i] + 1;
                    m_data[i]  = mem[i][b + m_beats[i]];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int n;
            int b;
            logic [AW-1:0] exp_addr;
            n = int'(num_of(i));
            b = int'(base_of(i));
            exp_addr = (m_active[i] && !m_load[i]) ? AW'((b + m_beats[i] + 1) % 32) : AW'(b);
            chk("wren", i, 64'(wren_o[i]), 64'd0);
            chk("valid", i, 64'(valid_o[i]), 64'(m_valid[i]));
            chk("busy", i, 64'(busy_o[i]), 64'(m_active[i]));
            chk("done", i, 64'(done_o[i]), 64'(m_done[i]));
            chk("last", i, 64'(last_o[i]), 64'(m_valid[i] && (m_beats[i] == n - 1)));
            chk("addr", i, 64'(addr_o[i]), 64'(exp_addr));
            if (m_valid[i] || m_fresh[i]) begin
                chk("data", i, 64'(data_o[i]), 64'(m_data[i]));
                chk("idx", i, 64'(idx_o[i]), 64'(m_fresh[i] ? 0 : m_beats[i]));
            end
`ifdef REGP_STREAM_SUM_EN
            chk("sum", i, 64'(sum_o[i]), 64'(m_sum[i]));
`endif
        end
    endtask

    // One clock: apply inputs, let the edge happen, advance model, check just after the edge
    task automatic cyc(input logic s, input logic r, input logic rs);
        start = s;
        ready = r;
        reset = rs;
        if (valid_o[0] === 1'b1 && r && !rs) xfer0++;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (done_o[0] === 1'b1) done_cnt0++;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 32; a++)
                mem[i][a] = (mode == 0) ? DW'(a + 1) : 45'h1FFFFFFFFFFF;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        start = 1'b0;
        ready = 1'b0;
        reset = 1'b1;
        xfer0 = 0;
        done_cnt0 = 0;
        for (int i = 0; i < NI; i++) begin
            m_active[i] = 0; m_load[i] = 0; m_valid[i] = 0; m_done[i] = 0;
            m_fresh[i] = 1; m_beats[i] = 0; m_data[i] = '0; m_sum[i] = '0;
        end
        fill(0);

        // Reset, including a start held high during reset
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_addr_base9", 1, 64'(addr_o[1]), 64'd9);
        chk("rst_valid", 0, 64'(valid_o[0]), 64'd0);
        idle(2);

        // Full frame with ready held high
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("first_valid_latency", 0, 64'(valid_o[0]), 64'd1);
        chk("first_data", 0, 64'(data_o[0]), 64'd1);
        for (int c = 0; c < 28; c++) cyc(1'b0, 1'b1, 1'b0);
`ifdef REGP_STREAM_SUM_EN
        chk("frame_sum", 0, 64'(sum_o[0]), 64'd276);
        chk("frame_sum", 1, 64'(sum_o[1]), 64'd483);
        chk("frame_sum", 2, 64'(sum_o[2]), 64'd32);
`endif
        idle(3);

        // Ready toggling 1,0,0: no beat lost or duplicated
        xfer0 = 0;
        done_cnt0 = 0;
        cyc(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 80; c++) cyc(1'b0, (c % 3) == 0, 1'b0);
        chk("toggle_xfers", 0, 64'(xfer0), 64'd23);
        chk("toggle_done_cnt", 0, 64'(done_cnt0), 64'd1);
        idle(3);

        // All-ones words: no wrap reading 9..31, no sum overflow
        fill(1);
        cyc(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 30; c++) cyc(1'b0, 1'b1, 1'b0);
`ifdef REGP_STREAM_SUM_EN
        chk("ones_sum", 0, 64'(sum_o[0]), 64'(50'd23 * 50'h1FFFFFFFFFFF));
        chk("ones_sum", 1, 64'(sum_o[1]), 64'(50'd23 * 50'h1FFFFFFFFFFF));
`endif
        idle(3);

        // Extra start pulses during beat 5 and in the DONE cycle are ignored
        fill(0);
        xfer0 = 0;
        done_cnt0 = 0;
        cyc(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 40; c++)
            cyc((m_valid[0] && m_beats[0] == 5) || m_done[0], 1'b1, 1'b0);
        chk("restart_ignored_xfers", 0, 64'(xfer0), 64'd23);
        chk("restart_ignored_done_cnt", 0, 64'(done_cnt0), 64'd1);
        idle(3);

        // Reset at coef_idx 10 abandons the frame
        done_cnt0 = 0;
        cyc(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (m_valid[0] && m_beats[0] == 10) begin
                chk("pre_reset_idx", 0, 64'(idx_o[0]), 64'd10);
                cyc(1'b0, 1'b1, 1'b1);
                break;
            end
            cyc(1'b0, 1'b1, 1'b0);
        end
        chk("post_reset_valid", 0, 64'(valid_o[0]), 64'd0);
        chk("post_reset_busy", 0, 64'(busy_o[0]), 64'd0);
        chk("post_reset_addr", 1, 64'(addr_o[1]), 64'd9);
        idle(3);
        chk("post_reset_no_done", 0, 64'(done_cnt0), 64'd0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("restart_idx", 0, 64'(idx_o[0]), 64'd0);
        chk("restart_data", 0, 64'(data_o[0]), 64'd1);
        for (int c = 0; c < 30; c++) cyc(1'b0, 1'b1, 1'b0);

        // Random traffic: random words, rewrites mid-frame, random start/ready, rare resets
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 32; a++)
                mem[i][a] = DW'({$urandom(), $urandom()});
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0)
                mem[$urandom_range(NI - 1)][$urandom_range(31)] = DW'({$urandom(), $urandom()});
            cyc($urandom_range(7) == 0, $urandom_range(1) == 1, $urandom_range(199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
